// File: rtl/control_unit_fsm.sv
// Multi-cycle control unit: latches one instruction, steps it DECODE/READ/EXEC/WB, owns result+flag regs.
// Latency 6 cycles accept-to-idle at best; instr_ready only in IDLE, EXEC waits on alu_done up to EXEC_TIMEOUT.
module control_unit_fsm #(
    parameter int INSTR_W      = 32,
    parameter int OP_W         = 4,
    parameter int ADDR_W       = 5,
    parameter int NUM_W        = 8,
    parameter int FLAG_W       = 4,
    parameter int EXEC_TIMEOUT = 16,
    parameter int ZERO_REG     = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [OP_W-1:0]    opcode,
    output logic [ADDR_W-1:0]  addr1,
    output logic [ADDR_W-1:0]  addr2,
    output logic [ADDR_W-1:0]  addr3,
    output logic [NUM_W-1:0]   number,
    output logic               imm_sel,
    output logic               rf_rd_en,
    output logic               alu_start,
    input  logic               alu_done,
    input  logic [NUM_W-1:0]   alu_result,
    input  logic [FLAG_W-1:0]  alu_flags,
    output logic               rf_wr_en,
    output logic [NUM_W-1:0]   output_CU,
    output logic [FLAG_W-1:0]  flag_CU,
    output logic               busy,
    output logic               halted,
    output logic               err
);
    localparam int A1_HI = INSTR_W - OP_W - 1;
    localparam int A2_HI = A1_HI - ADDR_W;
    localparam int A3_HI = A2_HI - ADDR_W;
    localparam int CNT_W = $clog2(EXEC_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [OP_W-1:0]     opcode_q, opcode_d;
    logic [ADDR_W-1:0]   addr1_q, addr1_d;
    logic [ADDR_W-1:0]   addr2_q, addr2_d;
    logic [ADDR_W-1:0]   addr3_q, addr3_d;
    logic [NUM_W-1:0]    number_q, number_d;
    logic                imm_sel_q, imm_sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_W-1:0]    out_q, out_d;
    logic [FLAG_W-1:0]   flag_q, flag_d;
    logic                err_q, err_d;
    logic [OP_W-1:0]     ir_op;
    logic                unused_ir;

    assign ir_op     = ir_q[INSTR_W-1 -: OP_W];
    // Gap bits between addr3 and the immediate are carried in the IR but never decoded.
    assign unused_ir = ^ir_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            opcode_q  <= '0;
            addr1_q   <= '0;
            addr2_q   <= '0;
            addr3_q   <= '0;
            number_q  <= '0;
            imm_sel_q <= 1'b0;
            cnt_q     <= '0;
            out_q     <= '0;
            flag_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            opcode_q  <= opcode_d;
            addr1_q   <= addr1_d;
            addr2_q   <= addr2_d;
            addr3_q   <= addr3_d;
            number_q  <= number_d;
            imm_sel_q <= imm_sel_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            flag_q    <= flag_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        opcode_d    = opcode_q;
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        addr3_d     = addr3_q;
        number_d    = number_q;
        imm_sel_d   = imm_sel_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        flag_d      = flag_q;
        err_d       = err_q;
        instr_ready = 1'b0;
        rf_rd_en    = 1'b0;
        alu_start   = 1'b0;
        rf_wr_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d    = instruction;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                opcode_d  = ir_op;
                addr1_d   = ir_q[A1_HI -: ADDR_W];
                addr2_d   = ir_q[A2_HI -: ADDR_W];
                addr3_d   = ir_q[A3_HI -: ADDR_W];
                number_d  = ir_q[NUM_W-1:0];
                imm_sel_d = ir_op[OP_W-1];
                if (ir_op == '0) begin
                    state_d = S_IDLE;
                end else if (&ir_op) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rf_rd_en = 1'b1;
                cnt_d    = '0;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                // cnt_q==0 is the start cycle; alu_done is only honoured after it.
                alu_start = (cnt_q == '0);
                if ((cnt_q != '0) && alu_done) begin
                    out_d   = alu_result;
                    flag_d  = alu_flags;
                    state_d = S_WB;
                end else if (cnt_q == CNT_W'(EXEC_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                rf_wr_en = !((ZERO_REG != 0) && (addr1_q == '0));
                state_d  = S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign opcode    = opcode_q;
    assign addr1     = addr1_q;
    assign addr2     = addr2_q;
    assign addr3     = addr3_q;
    assign number    = number_q;
    assign imm_sel   = imm_sel_q;
    assign output_CU = out_q;
    assign flag_CU   = flag_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE);
    assign halted    = (state_q == S_HALT);
endmodule

// File: doc/control_unit_fsm.md
Name: control_unit_fsm

Overview:
Parametrised, multi-cycle successor to the combinational control unit. It accepts instructions over a valid/ready handshake and latches them into an instruction register. It then steps each instruction through DECODE, READ, EXEC and WRITEBACK, driving register-file and ALU strobes. It sits between instruction fetch and the datapath (register file + ALU), and owns the architectural flag register and the result register.

Parameters:
INSTR_W, 32, instruction width; must satisfy OP_W+3*ADDR_W+NUM_W <= INSTR_W
OP_W, 4, opcode width
ADDR_W, 5, register address width
NUM_W, 8, immediate/number and result width
FLAG_W, 4, flag register width (Z,N,C,V at default)
EXEC_TIMEOUT, 16, max EXEC cycles waiting for alu_done
ZERO_REG, 1, 1 = writes to register address 0 are suppressed

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
instruction  in  INSTR_W  instruction word
instr_valid  in  1  instruction present
instr_ready  out  1  block can accept an instruction
opcode  out  OP_W  registered opcode field, instruction[INSTR_W-1 -: OP_W]
addr1  out  ADDR_W  destination address, next field down
addr2  out  ADDR_W  source A address, next field down
addr3  out  ADDR_W  source B address, next field down
number  out  NUM_W  immediate, instruction[NUM_W-1:0]
imm_sel  out  1  opcode[OP_W-1]; ALU operand B = number
rf_rd_en  out  1  register-file read strobe
alu_start  out  1  ALU start pulse
alu_done  in  1  ALU result valid
alu_result  in  NUM_W  ALU result
alu_flags  in  FLAG_W  ALU flags
rf_wr_en  out  1  register-file write strobe; write address = addr1
output_CU  out  NUM_W  last committed result
flag_CU  out  FLAG_W  last committed flags
busy  out  1  state != IDLE
halted  out  1  HALT state
err  out  1  sticky EXEC timeout error

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0 except instr_ready=1. An in-flight instruction is abandoned and no rf_wr_en is issued.
- States: IDLE, DECODE, READ, EXEC, WB, HALT.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instruction into the IR and go to DECODE. instr_ready is 0 in every other state.
- DECODE (1 cycle): field registers and imm_sel are updated from the IR and stay stable until the next DECODE.
  - opcode==0 (NOP): return to IDLE.
  - opcode all-ones: go to HALT.
  - otherwise: go to READ.
- READ (1 cycle): rf_rd_en=1, then go to EXEC.
- EXEC:
  - alu_start=1 on the first EXEC cycle only. A cycle counter is cleared on entry.
  - alu_done is sampled from the cycle after alu_start onward. When alu_done=1: output_CU<=alu_result, flag_CU<=alu_flags, go to WB.
  - If the counter reaches EXEC_TIMEOUT without alu_done: err<=1, go to IDLE. No writeback; output_CU and flag_CU are unchanged.
- WB (1 cycle): rf_wr_en=1, except rf_wr_en=0 when ZERO_REG=1 and addr1==0. Then go to IDLE.
- HALT: halted=1, instr_ready=0. Exit only by reset.
- Minimum latency, accept to return to IDLE, with alu_done at the earliest cycle:
  - accept edge at c0
  - DECODE c1, READ c2, EXEC c3 (start), done c4
  - WB c5, IDLE c6
- Throughput is one instruction per 6 cycles at best.
- alu_done outside EXEC, and instr_valid outside IDLE, are ignored.
- err is cleared only by reset.

Test Plan:
- Reset asserted mid-EXEC -> within the same cycle state=IDLE, instr_ready=1, all other outputs 0; no rf_wr_en ever seen.
- instruction=0x2190A02A, alu_done one cycle after alu_start, alu_result=0x55, alu_flags=4'b0000:
  - DECODE gives opcode=2, addr1=3, addr2=4, addr3=5, number=0x2A, imm_sel=0
  - rf_rd_en at c2, alu_start at c3, rf_wr_en at c5
  - output_CU=0x55, instr_ready high again at c6
- NOP (0x00000000) -> DECODE then IDLE; no rf_rd_en, alu_start or rf_wr_en; output_CU/flag_CU unchanged.
- Opcode 0xA with addr1=0 -> imm_sel=1, full sequence runs, rf_wr_en stays 0 in WB; output_CU and flag_CU still update.
- alu_done held low -> after 16 EXEC cycles err=1 and return to IDLE with no rf_wr_en; next valid instruction is accepted normally and err stays 1.
- instruction=0xF0000000 -> halted=1, instr_ready=0 indefinitely with instr_valid held high; reset clears halted.
